// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_e      FSM state encoding (S_IDLE=0, S_SHIFT=1, S_HOLD=2)
//   frame_len()  bits per frame for a given data width
//   even_parity() XOR-reduction used for the parity check
// Configuration macro: SIPO_PARITY_EN (adds one even-parity bit per frame).
// -----------------------------------------------------------------------------
package sipo_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

   // Serial bits consumed per output word.
   function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   // Returns 1 when the word holds an odd number of ones.
   function automatic logic even_parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// -----------------------------------------------------------------------------
// sipo_deserializer_if
// Serial input and parallel output channels of the deserializer.
//   sin, sin_valid, sin_ready          serial bit channel
//   par_out, out_valid, out_ready      parallel word channel
//   parity_err                         qualified by out_valid
// Handshake: on both channels a transfer happens on a rising clock edge where
// valid and ready are both 1. The sender keeps its payload stable while
// valid=1 and ready=0; ready never depends combinationally on valid.
// Modports: master = upstream producer / downstream consumer (testbench side),
//           slave  = the deserializer.
// -----------------------------------------------------------------------------
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             sin;
   logic             sin_valid;
   logic             sin_ready;
   logic [WIDTH-1:0] par_out;
   logic             out_valid;
   logic             out_ready;
   logic             parity_err;

   modport master (
      output sin, sin_valid, out_ready,
      input  sin_ready, par_out, out_valid, parity_err
   );

   modport slave (
      input  sin, sin_valid, out_ready,
      output sin_ready, par_out, out_valid, parity_err
   );
endinterface

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// WIDTH-bit shift register that assembles serial bits into a word.
//   clk, reset   clock and synchronous active-high reset
//   shift_en_i   shift din_i into the register this cycle
//   din_i        serial data bit
//   clear_i      empty the register (wins over shift_en_i)
//   data_o       registered contents
//   next_o       contents after shifting din_i in (lets the owner capture a
//                completed word on the same edge that takes its last bit)
// MSB_FIRST=0: bits enter at the top and move down, so the first bit ends in
// bit 0 after WIDTH shifts. MSB_FIRST=1: bits enter at bit 0 and move up.
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en_i,
   input  logic             din_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign next_o = {data_q[WIDTH-2:0], din_i};
      end else begin : g_lsb_first
         assign next_o = {din_i, data_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      if (clear_i) begin
         data_d = '0;
      end else if (shift_en_i) begin
         data_d = next_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
// Deserializer fed by a registered serial bit stream. Collects FRAME bits,
// presents each WIDTH-bit word through a one-word output buffer, and keeps
// shifting the next word while the buffered word waits for out_ready.
// Ports:
//   clk, reset    single clock, synchronous active-high reset
//   bus (slave)   sin/sin_valid/sin_ready, par_out/out_valid/out_ready,
//                 parity_err
//   dbg_state_o   current FSM state
//   dbg_count_o   bits accepted in the current frame
// Configuration macro: SIPO_PARITY_EN -- frames carry a trailing even-parity
// bit (FRAME=WIDTH+1) and parity_err reports a failure. Without it FRAME=WIDTH
// and parity_err is 0.
// -----------------------------------------------------------------------------
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int FRAME     = frame_len(WIDTH),
   localparam int CW        = $clog2(FRAME + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   sipo_deserializer_if.slave   bus,
   output state_e               dbg_state_o,
   output logic [CW-1:0]        dbg_count_o
);

   state_e           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] par_q, par_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;

   logic             sin_ready;
   logic             accept;
   logic             take;
   logic             last_bit;
   logic             buf_free;
   logic             sr_shift;
   logic             sr_clear;
   logic [WIDTH-1:0] sr_data;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] frame_word;
   logic             frame_perr;
   logic             held_perr;

   assign sin_ready = (state_q != S_HOLD);
   assign accept    = bus.sin_valid & sin_ready;
   assign take      = valid_q & bus.out_ready;
   assign last_bit  = accept && (count_q == CW'(FRAME - 1));
   // The buffer can accept a new word if empty or emptied on this same edge.
   assign buf_free  = !valid_q || take;
   // Data bits only; a trailing parity bit is never shifted in.
   assign sr_shift  = accept && (count_q < CW'(WIDTH));

`ifdef SIPO_PARITY_EN
   logic pbit_q;
   logic unused_sr_next;

   // Parity bit arrives after the data bits, so the register is already full.
   assign frame_word     = sr_data;
   assign frame_perr     = even_parity(32'(sr_data)) ^ bus.sin;
   assign held_perr      = even_parity(32'(sr_data)) ^ pbit_q;
   assign unused_sr_next = ^sr_next;

   // Keep the parity bit of a frame parked in HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         pbit_q <= 1'b0;
      end else if (last_bit && !buf_free) begin
         pbit_q <= bus.sin;
      end
   end
`else
   // Last data bit is still in flight; take the word as it will be shifted.
   assign frame_word = sr_next;
   assign frame_perr = 1'b0;
   assign held_perr  = 1'b0;
`endif

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (sr_shift),
      .din_i      (bus.sin),
      .clear_i    (sr_clear),
      .data_o     (sr_data),
      .next_o     (sr_next)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      par_d    = par_q;
      valid_d  = valid_q;
      perr_d   = perr_q;
      sr_clear = 1'b0;

      case (state_q)
         S_IDLE, S_SHIFT: begin
            // A handshake empties the buffer unless a new word refills it below.
            if (take) begin
               valid_d = 1'b0;
            end
            if (accept) begin
               if (last_bit) begin
                  count_d = '0;
                  if (buf_free) begin
                     state_d  = S_IDLE;
                     par_d    = frame_word;
                     perr_d   = frame_perr;
                     valid_d  = 1'b1;
                     sr_clear = 1'b1;
                  end else begin
                     state_d = S_HOLD;
                  end
               end else begin
                  count_d = count_q + CW'(1);
                  state_d = S_SHIFT;
               end
            end
         end
         S_HOLD: begin
            // out_valid is necessarily 1 here; the parked word replaces it.
            if (take) begin
               state_d  = S_IDLE;
               par_d    = sr_data;
               perr_d   = held_perr;
               valid_d  = 1'b1;
               sr_clear = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         par_q   <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         par_q   <= par_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
      end
   end

   assign bus.sin_ready  = sin_ready;
   assign bus.par_out    = par_q;
   assign bus.out_valid  = valid_q;
   assign bus.parity_err = perr_q;
   assign dbg_state_o    = state_q;
   assign dbg_count_o    = count_q;

endmodule
